mult_arbiter: RTL and testbench

MULT_ARBITER -- requirements
Module: mult_arbiter

---
 rtl/mult_arb_pkg.sv | 21 ++
 rtl/rr_arbiter.sv | 36 +++
 rtl/top.sv | 41 ++++
 rtl/mult_arbiter.sv | 112 +++++++++++
 tb/tb_mult_arbiter.sv | 278 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/mult_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mult_arb_pkg
// Description : Shared types and widths for the multiplier arbiter slice.
// Revision    : 1.0 - initial release
// ============================================================================
package mult_arb_pkg;

    localparam int XW       = 7;
    localparam int YW       = 7;
    localparam int PW       = 18;
    localparam int NREQ_DEF = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        RESP = 2'd2
    } state_t;

endpackage : mult_arb_pkg
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : rr_arbiter
// Description : Round-robin pick starting one past the previous grant.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter #(
    parameter int NREQ = 4,
    parameter int IDW  = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDW-1:0]  last_grant,
    output logic [NREQ-1:0] grant,
    output logic [IDW-1:0]  grant_idx,
    output logic            any
);

    int w_k;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        any       = 1'b0;
        w_k       = 0;
        for (int i = 1; i <= NREQ; i++) begin
            w_k = (int'(last_grant) + i) % NREQ;
            if (!any && req[w_k]) begin
                any        = 1'b1;
                grant[w_k] = 1'b1;
                grant_idx  = IDW'(w_k);
            end
        end
    end

endmodule : rr_arbiter
`default_nettype wire

// File: rtl/top.sv
`default_nettype none
// ============================================================================
// Module      : top
// Description : Combinational radix-4 unsigned multiplier, 7b x 7b -> 18b.
// Revision    : 1.0 - initial release
// ============================================================================
module top (
    input  logic [6:0]  x,
    input  logic [6:0]  y,
    output logic [17:0] p
);

    logic [7:0]  w_yx;
    logic [17:0] w_pp [4];

    assign w_yx = {1'b0, y};

    // One partial product per base-4 digit of y: 0, x, 2x or 3x.
    for (genvar k = 0; k < 4; k++) begin : g_pp
        logic [1:0] w_d;
        logic [8:0] w_m;

        assign w_d = w_yx[2*k+1:2*k];

        always_comb begin
            w_m = 9'd0;
            case (w_d)
                2'd1:    w_m = {2'b00, x};
                2'd2:    w_m = {1'b0, x, 1'b0};
                2'd3:    w_m = {2'b00, x} + {1'b0, x, 1'b0};
                default: w_m = 9'd0;
            endcase
        end

        assign w_pp[k] = {9'd0, w_m} << (2 * k);
    end

    assign p = w_pp[0] + w_pp[1] + w_pp[2] + w_pp[3];

endmodule : top
`default_nettype wire

// File: rtl/mult_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mult_arbiter
// Description : Shares one multiplier among NREQ requesters, round-robin.
// Revision    : 1.0 - initial release
// ============================================================================
module mult_arbiter
    import mult_arb_pkg::*;
#(
    parameter int NREQ = NREQ_DEF,
    parameter int IDW  = $clog2(NREQ)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NREQ-1:0]    req_valid,
    output logic [NREQ-1:0]    req_ready,
    input  logic [NREQ*XW-1:0] req_x,
    input  logic [NREQ*YW-1:0] req_y,
    output logic               resp_valid,
    input  logic               resp_ready,
    output logic [PW-1:0]      resp_p,
    output logic [IDW-1:0]     resp_id,
    output logic               busy
);

    state_t          r_state;
    state_t          w_state_nxt;
    logic [XW-1:0]   r_x;
    logic [YW-1:0]   r_y;
    logic [IDW-1:0]  r_id;
    logic [IDW-1:0]  r_last;
    logic [IDW-1:0]  r_resp_id;
    logic [PW-1:0]   r_p;
    logic [PW-1:0]   w_p;
    logic [NREQ-1:0] w_grant;
    logic [IDW-1:0]  w_gidx;
    logic            w_any;
    logic            w_open;
    logic            w_accept;

    rr_arbiter #(
        .NREQ (NREQ),
        .IDW  (IDW)
    ) u_arb (
        .req        (req_valid),
        .last_grant (r_last),
        .grant      (w_grant),
        .grant_idx  (w_gidx),
        .any        (w_any)
    );

    top u_mult (
        .x (r_x),
        .y (r_y),
        .p (w_p)
    );

    // w_open marks cycles where a new operand pair may be taken.
    always_comb begin
        w_open      = 1'b0;
        w_state_nxt = r_state;
        case (r_state)
            IDLE: begin
                w_open = 1'b1;
                if (w_any) w_state_nxt = CALC;
            end
            CALC: w_state_nxt = RESP;
            RESP: begin
                if (resp_ready) begin
                    w_open      = 1'b1;
                    w_state_nxt = w_any ? CALC : IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
        w_accept  = w_open && w_any && !rst;
        req_ready = w_accept ? w_grant : '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= IDLE;
            r_x       <= '0;
            r_y       <= '0;
            r_id      <= '0;
            r_last    <= IDW'(NREQ - 1);
            r_p       <= '0;
            r_resp_id <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_accept) begin
                r_x    <= req_x[int'(w_gidx)*XW +: XW];
                r_y    <= req_y[int'(w_gidx)*YW +: YW];
                r_id   <= w_gidx;
                r_last <= w_gidx;
            end
            // Response registers are separate so they stay frozen in RESP
            // even when the operand registers take the next pair.
            if (r_state == CALC) begin
                r_p       <= w_p;
                r_resp_id <= r_id;
            end
        end
    end

    assign resp_valid = (r_state == RESP);
    assign busy       = (r_state != IDLE);
    assign resp_p     = r_p;
    assign resp_id    = r_resp_id;

endmodule : mult_arbiter
`default_nettype wire

// File: tb/tb_mult_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_mult_arbiter
// Description : Scoreboard bench for mult_arbiter with a behavioural model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mult_arbiter;

    localparam int N  = 4;
    localparam int IW = 2;

    logic            clk        = 1'b0;
    logic            rst        = 1'b1;
    logic [N-1:0]    req_valid  = '0;
    logic [N-1:0]    req_ready;
    logic [N*7-1:0]  req_x      = '0;
    logic [N*7-1:0]  req_y      = '0;
    logic            resp_valid;
    logic            resp_ready = 1'b1;
    logic [17:0]     resp_p;
    logic [IW-1:0]   resp_id;
    logic            busy;

    int checks   = 0;
    int failures = 0;

    // Behavioural model state
    int exp_id_q[$];
    int exp_p_q[$];
    int cyc       = 0;
    int m_last    = N - 1;
    int m_resp_at = 0;
    bit m_pending = 1'b0;
    bit rst_chk   = 1'b0;
    bit mon_exp_v;
    int pr_g;
    int pr_rdy;
    int pr_x;
    int pr_y;

    mult_arbiter #(.NREQ(N), .IDW(IW)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_x      (req_x),
        .req_y      (req_y),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_p     (resp_p),
        .resp_id    (resp_id),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // First valid index at or after last+1, wrapping.
    function automatic int rr_pick(input logic [N-1:0] v, input int last);
        for (int i = 1; i <= N; i++) begin
            if (v[(last + i) % N]) return (last + i) % N;
        end
        return -1;
    endfunction

    task automatic set_op(input int i, input int xv, input int yv);
        req_x[7*i +: 7] = 7'(xv);
        req_y[7*i +: 7] = 7'(yv);
    endtask

    task automatic wait_resp(input string name, input int ep, input int eid);
        bit got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            if (resp_valid && resp_ready) begin
                got = 1'b1;
                chk({name, "_p"}, int'(resp_p), ep);
                chk({name, "_id"}, int'(resp_id), eid);
            end
        end
        if (!got) chk({name, "_timeout"}, 0, 1);
        @(posedge clk); #1;
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    // Monitor: response timing, stability and contents against the queue.
    always @(negedge clk) begin
        if (!rst) begin
            if (rst_chk) begin
                chk("rst_resp_valid", int'(resp_valid), 0);
                chk("rst_resp_p", int'(resp_p), 0);
                chk("rst_resp_id", int'(resp_id), 0);
                chk("rst_busy", int'(busy), 0);
                rst_chk = 1'b0;
            end
            mon_exp_v = m_pending && (cyc >= m_resp_at);
            chk("resp_valid", int'(resp_valid), int'(mon_exp_v));
            chk("busy", int'(busy), int'(m_pending));
            if (resp_valid && mon_exp_v) begin
                if (exp_p_q.size() == 0) begin
                    chk("resp_unexpected", 0, 1);
                end else begin
                    chk("resp_p", int'(resp_p), exp_p_q[0]);
                    chk("resp_id", int'(resp_id), exp_id_q[0]);
                    if (resp_ready) begin
                        void'(exp_p_q.pop_front());
                        void'(exp_id_q.pop_front());
                        m_pending = 1'b0;
                    end
                end
            end
        end
    end

    // Predictor: expected grant, pushes the expected product on each accept.
    always @(negedge clk) begin
        #1;
        if (rst) begin
            chk("req_ready_in_rst", int'(req_ready), 0);
            exp_p_q.delete();
            exp_id_q.delete();
            m_pending = 1'b0;
            m_last    = N - 1;
            rst_chk   = 1'b1;
        end else begin
            pr_g   = m_pending ? -1 : rr_pick(req_valid, m_last);
            pr_rdy = (pr_g >= 0) ? (1 << pr_g) : 0;
            chk("req_ready", int'(req_ready), pr_rdy);
            if (pr_g >= 0) begin
                pr_x = int'(req_x[7*pr_g +: 7]);
                pr_y = int'(req_y[7*pr_g +: 7]);
                exp_p_q.push_back(pr_x * pr_y);
                exp_id_q.push_back(pr_g);
                m_last    = pr_g;
                m_pending = 1'b1;
                m_resp_at = cyc + 2;
            end
        end
        cyc++;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit got;
        rst        = 1'b1;
        resp_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        // Single request, two-cycle latency
        set_op(0, 5, 3);
        req_valid = 4'b0001;
        @(posedge clk); #1;
        req_valid = '0;
        wait_resp("basic", 15, 0);

        // Four requesters held valid from a fresh reset
        pulse_reset();
        for (int i = 0; i < N; i++) set_op(i, i + 1, 2);
        req_valid = 4'hF;
        wait_resp("rr0", 2, 0);
        wait_resp("rr1", 4, 1);
        wait_resp("rr2", 6, 2);
        wait_resp("rr3", 8, 3);
        wait_resp("rr4", 2, 0);
        req_valid = '0;
        repeat (4) @(posedge clk);
        #1;

        // Backpressure: response held while consumer stalls
        set_op(2, 63, 63);
        resp_ready = 1'b0;
        req_valid  = 4'hF;
        got = 1'b0;
        for (int i = 0; i < 10 && !got; i++) begin
            @(negedge clk);
            got = resp_valid;
        end
        if (!got) chk("bp_timeout", 0, 1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_valid", int'(resp_valid), 1);
            chk("bp_p", int'(resp_p), 3969);
            chk("bp_id", int'(resp_id), 2);
            chk("bp_ready", int'(req_ready), 0);
        end
        @(posedge clk); #1;
        resp_ready = 1'b1;
        req_valid  = '0;
        @(negedge clk);
        @(negedge clk);
        chk("bp_idle", int'(busy), 0);
        @(posedge clk); #1;

        // Requesters 1 and 3 after last grant 1
        set_op(1, 7, 9);
        req_valid = 4'b0010;
        @(posedge clk); #1;
        req_valid = '0;
        wait_resp("pre_rr", 63, 1);
        set_op(3, 10, 11);
        set_op(1, 12, 13);
        req_valid = 4'b1010;
        wait_resp("rr13_a", 110, 3);
        wait_resp("rr13_b", 156, 1);
        req_valid = '0;
        repeat (4) @(posedge clk);
        #1;

        // Reset during RESP discards the pending product
        resp_ready = 1'b0;
        set_op(0, 5, 3);
        set_op(2, 4, 4);
        req_valid = 4'b0101;
        @(posedge clk); #1;
        req_valid = '0;
        got = 1'b0;
        for (int i = 0; i < 10 && !got; i++) begin
            @(negedge clk);
            got = resp_valid;
        end
        if (!got) chk("mid_rst_timeout", 0, 1);
        @(posedge clk); #1;
        pulse_reset();
        @(negedge clk);
        chk("after_rst_valid", int'(resp_valid), 0);
        chk("after_rst_p", int'(resp_p), 0);
        chk("after_rst_busy", int'(busy), 0);
        @(posedge clk); #1;
        resp_ready = 1'b1;
        for (int i = 0; i < N; i++) set_op(i, 5, 3 + i);
        req_valid = 4'hF;
        wait_resp("post_rst", 15, 0);
        req_valid = '0;
        repeat (4) @(posedge clk);
        #1;

        // Randomized traffic with occasional reset
        for (int c = 0; c < 400; c++) begin
            req_valid = 4'($urandom_range(0, 15));
            for (int i = 0; i < N; i++) set_op(i, $urandom_range(0, 127), $urandom_range(0, 127));
            resp_ready = ($urandom_range(0, 9) < 7);
            rst        = ($urandom_range(0, 99) == 0);
            @(posedge clk); #1;
        end
        rst        = 1'b0;
        req_valid  = '0;
        resp_ready = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        chk("drained", exp_p_q.size(), 0);
        @(negedge clk);
        #2;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_mult_arbiter
`default_nettype wire
